// File: rtl/read_addr_gen_mc.sv
// Two-level (row/column) multi-port read address generator.
// One start pulse loads a loop descriptor; the block then walks
// num_outer rows of num_inner beats, one address per enabled port per beat,
// under a valid/ready handshake. Address arithmetic wraps modulo 2^DIM_ADDR.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold last addresses (0 after reset)
// RUN   | out_valid high, one beat per out_valid & out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module read_addr_gen_mc #(
  parameter int DIM_ADDR   = 12,
  parameter int DIM_CNT    = 8,
  parameter int DIM_STRIDE = 8,
  parameter int NUM_PORTS  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            start,
  input  logic [DIM_CNT-1:0]              num_inner,
  input  logic [DIM_CNT-1:0]              num_outer,
  input  logic [NUM_PORTS-1:0]            port_en,
  input  logic [NUM_PORTS*DIM_ADDR-1:0]   base_addr,
  input  logic [NUM_PORTS*DIM_STRIDE-1:0] inner_stride,
  input  logic [NUM_PORTS*DIM_STRIDE-1:0] outer_stride,
  input  logic                            out_ready,
  output logic [NUM_PORTS*DIM_ADDR-1:0]   out_addr,
  output logic                            out_valid,
  output logic                            out_last_inner,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIM_CNT-1:0] CNT_ONE = {{(DIM_CNT-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [NUM_PORTS-1:0][DIM_ADDR-1:0]   addr_q, row_q, addr_step, row_step;
  logic [NUM_PORTS-1:0][DIM_STRIDE-1:0] istride_q, ostride_q;
  logic [NUM_PORTS-1:0]                 en_q;
  logic [DIM_CNT-1:0]                   ci_q, co_q, n_inner_q, n_outer_q;
  logic                                 last_ci, last_co, fire, zero_len;

  function automatic logic [DIM_ADDR-1:0] sext(input logic [DIM_STRIDE-1:0] s);
    return {{(DIM_ADDR-DIM_STRIDE){s[DIM_STRIDE-1]}}, s};
  endfunction

  assign last_ci  = (ci_q == n_inner_q - CNT_ONE);
  assign last_co  = (co_q == n_outer_q - CNT_ONE);
  assign fire     = (state == RUN) && out_ready;
  assign zero_len = (num_inner == '0) || (num_outer == '0);

  // Candidate next addresses: column step within a row, and next row start.
  always_comb begin
    addr_step = '0;
    row_step  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_step[p] = addr_q[p] + sext(istride_q[p]);
      row_step[p]  = row_q[p] + sext(ostride_q[p]);
    end
  end

  // State register; rst and clr both abort straight to IDLE.
  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_len ? DONE : RUN;
      RUN:  if (fire && last_ci && last_co) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor capture and address/counter advance on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr_q    <= '0;
      row_q     <= '0;
      istride_q <= '0;
      ostride_q <= '0;
      en_q      <= '0;
      ci_q      <= '0;
      co_q      <= '0;
      n_inner_q <= '0;
      n_outer_q <= '0;
    end else if (state == IDLE && start) begin
      addr_q    <= base_addr;
      row_q     <= base_addr;
      istride_q <= inner_stride;
      ostride_q <= outer_stride;
      en_q      <= port_en;
      ci_q      <= '0;
      co_q      <= '0;
      n_inner_q <= num_inner;
      n_outer_q <= num_outer;
    end else if (fire) begin
      if (!last_ci) begin
        ci_q <= ci_q + CNT_ONE;
        for (int p = 0; p < NUM_PORTS; p++)
          if (en_q[p]) addr_q[p] <= addr_step[p];
      end else if (!last_co) begin
        ci_q <= '0;
        co_q <= co_q + CNT_ONE;
        for (int p = 0; p < NUM_PORTS; p++)
          if (en_q[p]) begin
            row_q[p]  <= row_step[p];
            addr_q[p] <= row_step[p];
          end
      end
    end
  end

  assign out_addr       = addr_q;
  assign out_valid      = (state == RUN);
  assign out_last_inner = (state == RUN) && last_ci;
  assign out_last       = out_last_inner && last_co;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_read_addr_gen_mc.sv
// Scoreboard bench for read_addr_gen_mc: expected beats are computed in closed
// form (base + ci*inner + co*outer, mod 4096) and compared on every valid cycle.
module tb_read_addr_gen_mc;

  localparam int DA = 12;
  localparam int DC = 8;
  localparam int DS = 8;
  localparam int NP = 3;

  logic             clk = 1'b0;
  logic             rst, clr, start, out_ready;
  logic [DC-1:0]    num_inner, num_outer;
  logic [NP-1:0]    port_en;
  logic [NP*DA-1:0] base_addr, out_addr;
  logic [NP*DS-1:0] inner_stride, outer_stride;
  logic             out_valid, out_last_inner, out_last, busy, done;

  read_addr_gen_mc #(.DIM_ADDR(DA), .DIM_CNT(DC), .DIM_STRIDE(DS), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .num_inner(num_inner), .num_outer(num_outer), .port_en(port_en),
    .base_addr(base_addr), .inner_stride(inner_stride), .outer_stride(outer_stride),
    .out_ready(out_ready), .out_addr(out_addr), .out_valid(out_valid),
    .out_last_inner(out_last_inner), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP*DA-1:0] addr;
    logic             li;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [NP*DA-1:0] base_v;
  logic [NP*DS-1:0] is_v, os_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected beats in traversal order; last_a is the address held after the final beat.
  task automatic push_model(input int ni, input int no, input logic [NP-1:0] en,
                            output logic [NP*DA-1:0] last_a);
    beat_t b;
    int    a, b0, si, so;
    last_a = base_v;
    for (int co = 0; co < no; co++)
      for (int ci = 0; ci < ni; ci++) begin
        b = '0;
        for (int p = 0; p < NP; p++) begin
          b0 = int'(base_v[p*DA +: DA]);
          si = $signed(is_v[p*DS +: DS]);
          so = $signed(os_v[p*DS +: DS]);
          a  = en[p] ? (b0 + ci*si + co*so) : b0;
          b.addr[p*DA +: DA] = a[DA-1:0];
        end
        b.li = (ci == ni-1);
        b.l  = (ci == ni-1) && (co == no-1);
        exp_q.push_back(b);
        last_a = b.addr;
      end
  endtask

  // Scoreboard monitor: every valid cycle must match the head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("beat_expected", 64'(exp_q.size()), 64'd1);
      else begin
        check("addr", out_addr, exp_q[0].addr);
        check("last_inner", out_last_inner, exp_q[0].li);
        check("last", out_last, exp_q[0].l);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_start(input int ni, input int no, input logic [NP-1:0] en);
    start        = 1'b1;
    num_inner    = DC'(ni);
    num_outer    = DC'(no);
    port_en      = en;
    base_addr    = base_v;
    inner_stride = is_v;
    outer_stride = os_v;
    tick;
    start        = 1'b0;
    num_inner    = DC'($urandom);
    num_outer    = DC'($urandom);
    port_en      = NP'($urandom);
    base_addr    = NP*DA'($urandom);
    inner_stride = NP*DS'($urandom);
    outer_stride = NP*DS'($urandom);
  endtask

  // exp_done > 0 requires done exactly that many cycles after start.
  task automatic run_desc(input string tag, input int ni, input int no, input logic [NP-1:0] en,
                          input bit rnd, input int exp_done);
    logic [NP*DA-1:0] last_a;
    int k;
    bit seen;
    push_model(ni, no, en, last_a);
    drive_start(ni, no, en);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 400) begin
      k++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
      else tick;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    if (exp_done > 0) check({tag, "_done_cycle"}, 64'(k), 64'(exp_done));
    check({tag, "_hold_addr"}, out_addr, last_a);
    check({tag, "_valid_in_done"}, 64'(out_valid), 64'd0);
    tick;
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    exp_q.delete();
    tick;
  endtask

  initial begin
    logic [NP*DA-1:0] dummy;
    rst = 1'b1; clr = 1'b0; start = 1'b0; out_ready = 1'b1;
    num_inner = '0; num_outer = '0; port_en = '0;
    base_addr = '0; inner_stride = '0; outer_stride = '0;
    repeat (3) tick;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", out_addr, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick;

    // 1-D, three ports with strides +1, +4, -1
    base_v = {12'h200, 12'h100, 12'h010};
    is_v   = {8'hFF, 8'h04, 8'h01};
    os_v   = '0;
    run_desc("1d", 4, 1, 3'b111, 1'b0, 5);

    // 2-D rows of 3, row step +16; other ports exercise wide strides
    base_v = {12'h7F0, 12'h300, 12'h040};
    is_v   = {8'h80, 8'h02, 8'h01};
    os_v   = {8'h7F, 8'hF0, 8'h10};
    run_desc("2d", 3, 2, 3'b111, 1'b0, 7);

    // Wrap in both directions
    base_v = {12'hFFF, 12'h002, 12'hFFE};
    is_v   = {8'h01, 8'h00, 8'h01};
    os_v   = {8'hFE, 8'hFC, 8'h00};
    run_desc("wrap", 4, 2, 3'b111, 1'b0, 9);

    // Backpressure with stray start pulses and changing descriptor inputs
    base_v = {12'h7F0, 12'h300, 12'h040};
    is_v   = {8'h80, 8'h02, 8'h01};
    os_v   = {8'h7F, 8'hF0, 8'h10};
    for (int r = 0; r < 3; r++) run_desc("bp", 3 + r, 2 + r, 3'b111, 1'b1, 0);

    // Zero-length descriptors
    run_desc("zero_outer", 5, 0, 3'b111, 1'b0, 1);
    run_desc("zero_inner", 0, 3, 3'b111, 1'b0, 1);

    // Port 1 disabled holds its base
    base_v = {12'h020, 12'h5A5, 12'h040};
    is_v   = {8'h03, 8'h07, 8'h01};
    os_v   = {8'h10, 8'h33, 8'h10};
    run_desc("port_en", 3, 2, 3'b101, 1'b0, 7);

    // clr during beat 3 of 6: abort, no done, outputs cleared
    base_v = {12'h7F0, 12'h300, 12'h040};
    is_v   = {8'h80, 8'h02, 8'h01};
    os_v   = {8'h7F, 8'hF0, 8'h10};
    push_model(3, 2, 3'b111, dummy);
    drive_start(3, 2, 3'b111);
    out_ready = 1'b1;
    tick;
    tick;
    clr = 1'b1;
    @(negedge clk);
    check("clr_pre_valid", 64'(out_valid), 64'd1);
    tick;
    clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_addr", out_addr, 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    tick;
    @(negedge clk);
    check("clr_no_done_later", 64'(done), 64'd0);
    tick;
    run_desc("after_clr", 3, 2, 3'b111, 1'b0, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
